// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone initiator slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;

  // Byte-select width for a given data width.
  function automatic int wb_sel_w(input int dat_w);
    return dat_w / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts Wishbone wait cycles and flags the last permitted one.
// Latency: expire is combinational from the current count and enable.
// Backpressure: none; it stops counting at expiry so it never wraps.
module wb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

  // Count ack-less bus cycles; hold at the last value once expiry fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one bus cycle per command, result on a response port.
// Latency: cyc/stb from the edge after command accept until ack (or TIMEOUT cycles).
// Backpressure: cmd_ready_o only in IDLE; response held until rsp_ready_i.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_we_i,
  input  logic [ADR_W-1:0]            cmd_adr_i,
  input  logic [DAT_W-1:0]            cmd_dat_i,
  input  logic [wb_sel_w(DAT_W)-1:0]  cmd_sel_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DAT_W-1:0]            rsp_dat_o,
  output logic                        rsp_err_o,
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [ADR_W-1:0]            wbm_adr_o,
  output logic [DAT_W-1:0]            wbm_dat_o,
  output logic [wb_sel_w(DAT_W)-1:0]  wbm_sel_o,
  input  logic                        wbm_ack_i,
  input  logic [DAT_W-1:0]            wbm_dat_i
);

  localparam int SEL_W = wb_sel_w(DAT_W);

  wb_state_e state_q, state_d;

  logic             cyc_d;
  logic             we_d;
  logic [ADR_W-1:0] adr_d;
  logic [DAT_W-1:0] dat_d;
  logic [SEL_W-1:0] sel_d;
  logic             rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_d;
  logic             rsp_err_d;
  logic             cnt_clear;
  logic             cnt_en;
  logic             expire;

  assign cmd_ready_o = (state_q == IDLE);

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expire (expire)
  );

  // Next-state and next-output decode; every register holds unless a rule moves it.
  always_comb begin
    state_d     = state_q;
    cyc_d       = wbm_cyc_o;
    we_d        = wbm_we_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    sel_d       = wbm_sel_o;
    rsp_valid_d = rsp_valid_o;
    rsp_dat_d   = rsp_dat_o;
    rsp_err_d   = rsp_err_o;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d      = cmd_we_i;
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          sel_d     = cmd_sel_i;
          cyc_d     = 1'b1;
          cnt_clear = 1'b1;
          state_d   = BUS;
        end
      end

      BUS: begin
        // Ack takes priority over a simultaneous timeout expiry.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_en = 1'b1;
          if (expire) begin
            cyc_d       = 1'b0;
            rsp_dat_d   = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; a reset mid-cycle drops cyc/stb and any pending response.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= cyc_d;
      wbm_we_o    <= we_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      wbm_sel_o   <= sel_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_dat_o   <= rsp_dat_d;
      rsp_err_o   <= rsp_err_d;
    end
  end

endmodule
